// File: rtl/processor_pkg.sv
// Shared processor definitions: default data-memory geometry and the
// read-return owner encoding used by dmem_arbiter.
package processor_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/grant/read-return bundle for one requester of the shared data memory.
// master = requester (core or host), slave = the arbiter.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter_wait_counter.sv
// arb_wait_counter: saturating 8-bit count of cycles the host has waited,
// with synchronous clear and a compare against MAX_WAIT.
module arb_wait_counter #(
    parameter int MAX_WAIT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] count,
    output logic       at_max
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign at_max = (count == 8'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core MEM stage (priority) and the host port.
// Define DMEM_ARB_STARVE_EN to force a host slot once host_wait reaches MAX_WAIT.
module dmem_arbiter
    import processor_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 8
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave cpu,
    dmem_arbiter_if.slave host,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    host_wait
);

`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic       cpu_gnt;
    logic       host_gnt;
    logic       force_host;
    logic       wait_at_max;
    logic [1:0] owner;

    // Counter keeps running without the forced slot so host_wait stays useful for debug.
    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
        .clock  (clock),
        .reset  (reset),
        .inc    (host.req && !host_gnt),
        .clr    (!host.req || host_gnt),
        .count  (host_wait),
        .at_max (wait_at_max)
    );

    assign force_host = STARVE_EN && host.req && wait_at_max;
    assign cpu_gnt    = cpu.req && !force_host;
    assign host_gnt   = host.req && !cpu_gnt;

    always_comb begin
        mem_en    = cpu_gnt || host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu.we;
            mem_addr  = cpu.addr;
            mem_wdata = cpu.wdata;
        end else if (host_gnt) begin
            mem_we    = host.we;
            mem_addr  = host.addr;
            mem_wdata = host.wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner <= OWN_NONE;
        end else if (cpu_gnt && !cpu.we) begin
            owner <= OWN_CPU;
        end else if (host_gnt && !host.we) begin
            owner <= OWN_HOST;
        end else begin
            owner <= OWN_NONE;
        end
    end

    assign cpu.gnt     = cpu_gnt;
    assign host.gnt    = host_gnt;
    assign cpu.rvalid  = (owner == OWN_CPU);
    assign host.rvalid = (owner == OWN_HOST);
    assign cpu.rdata   = (owner == OWN_CPU)  ? mem_rdata : '0;
    assign host.rdata  = (owner == OWN_HOST) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a write-first RAM model and a read scoreboard.
// Starvation expectations follow DMEM_ARB_STARVE_EN.
module tb_dmem_arbiter;
    import processor_pkg::*;

    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int MAX_WAIT = 8;
`ifdef DMEM_ARB_STARVE_EN
    localparam int STARVE_BOUND = 40;
`else
    localparam int STARVE_BOUND = 300;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) cpu_if ();
    dmem_arbiter_if #(.AW(AW), .DW(DW)) host_if ();

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [7:0]    host_wait;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu       (cpu_if),
        .host      (host_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .host_wait (host_wait)
    );

    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];

    // Write-first single-port RAM, read data one cycle after enable.
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] cpu_q  [$];
    logic [DW-1:0] host_q [$];

    // Scoreboard: pop last cycle's expected read data, then record this cycle's accepted accesses.
    always @(negedge clock) begin
        logic [DW-1:0] e;
        if (reset) begin
            if (cpu_q.size() != 0) begin
                e = cpu_q.pop_front();
                chk("cpu_rvalid", 32'(cpu_if.rvalid), 32'd1);
                if (cpu_if.rvalid) chk("cpu_rdata", 32'(cpu_if.rdata), 32'(e));
            end else if (cpu_if.rvalid) begin
                chk("cpu_spurious_rvalid", 32'(cpu_if.rvalid), 32'd0);
            end
            if (host_q.size() != 0) begin
                e = host_q.pop_front();
                chk("host_rvalid", 32'(host_if.rvalid), 32'd1);
                if (host_if.rvalid) chk("host_rdata", 32'(host_if.rdata), 32'(e));
            end else if (host_if.rvalid) begin
                chk("host_spurious_rvalid", 32'(host_if.rvalid), 32'd0);
            end
            if (cpu_if.gnt && host_if.gnt)
                chk("gnt_exclusive", 32'(cpu_if.gnt & host_if.gnt), 32'd0);
            if (cpu_if.req && cpu_if.gnt) begin
                if (cpu_if.we) ref_mem[cpu_if.addr] = cpu_if.wdata;
                else           cpu_q.push_back(ref_mem[cpu_if.addr]);
            end
            if (host_if.req && host_if.gnt) begin
                if (host_if.we) ref_mem[host_if.addr] = host_if.wdata;
                else            host_q.push_back(ref_mem[host_if.addr]);
            end
        end
    end

    task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_if.req   = r;
        cpu_if.we    = w;
        cpu_if.addr  = a;
        cpu_if.wdata = d;
    endtask

    task automatic set_host(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_if.req   = r;
        host_if.we    = w;
        host_if.addr  = a;
        host_if.wdata = d;
    endtask

    task automatic next_drive();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic rc, rh;
        int   gnt_cycle;
        logic cpu_at;
        logic [7:0] wait_at;

        for (int i = 0; i < 256; i++) ram[i] = 16'(i * 7 + 3);
        ram[8'h10] = 16'h1234;
        ram[8'h30] = 16'h5A5A;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
        set_cpu(1'b0, 1'b0, '0, '0);
        set_host(1'b0, 1'b0, '0, '0);

        // Reset held with random traffic
        for (int i = 0; i < 8; i++) begin
            next_drive();
            rc = 1'($urandom);
            rh = 1'($urandom);
            set_cpu(rc, 1'($urandom), 8'($urandom), 16'($urandom));
            set_host(rh, 1'($urandom), 8'($urandom), 16'($urandom));
            @(negedge clock);
            chk("rst_cpu_rvalid", 32'(cpu_if.rvalid), 32'd0);
            chk("rst_host_rvalid", 32'(host_if.rvalid), 32'd0);
            chk("rst_host_wait", 32'(host_wait), 32'd0);
            chk("rst_cpu_gnt", 32'(cpu_if.gnt), 32'(rc));
            chk("rst_host_gnt", 32'(host_if.gnt), 32'(rh && !rc));
        end
        next_drive();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_host(1'b0, 1'b0, '0, '0);
        reset = 1'b1;

        // First host read after reset
        next_drive();
        set_host(1'b1, 1'b0, 8'h10, '0);
        @(negedge clock);
        chk("first_host_gnt", 32'(host_if.gnt), 32'd1);
        next_drive();
        set_host(1'b0, 1'b0, '0, '0);
        @(negedge clock);
        chk("first_host_rvalid", 32'(host_if.rvalid), 32'd1);
        chk("first_host_rdata", 32'(host_if.rdata), 32'h1234);

        // Contention: CPU read vs host write
        next_drive();
        set_cpu(1'b1, 1'b0, 8'h05, '0);
        set_host(1'b1, 1'b1, 8'h06, 16'hBEEF);
        @(negedge clock);
        chk("cont_cpu_gnt", 32'(cpu_if.gnt), 32'd1);
        chk("cont_host_gnt", 32'(host_if.gnt), 32'd0);
        next_drive();
        set_cpu(1'b0, 1'b0, '0, '0);
        @(negedge clock);
        chk("cont_host_gnt2", 32'(host_if.gnt), 32'd1);
        chk("cont_host_wait", 32'(host_wait), 32'd1);
        chk("cont_cpu_rdata", 32'(cpu_if.rdata), 32'(16'(5 * 7 + 3)));
        next_drive();
        set_host(1'b1, 1'b0, 8'h06, '0);
        @(negedge clock);
        chk("cont_rd_gnt", 32'(host_if.gnt), 32'd1);
        next_drive();
        set_host(1'b0, 1'b0, '0, '0);
        @(negedge clock);
        chk("cont_readback", 32'(host_if.rdata), 32'hBEEF);
        chk("cont_ram", 32'(ram[8'h06]), 32'hBEEF);

        // Back-to-back write then read of the same address
        next_drive();
        set_cpu(1'b1, 1'b1, 8'h20, 16'hAAAA);
        @(negedge clock);
        chk("b2b_wr_gnt", 32'(cpu_if.gnt), 32'd1);
        next_drive();
        set_cpu(1'b1, 1'b0, 8'h20, '0);
        @(negedge clock);
        chk("b2b_rd_gnt", 32'(cpu_if.gnt), 32'd1);
        chk("b2b_no_rvalid_after_wr", 32'(cpu_if.rvalid), 32'd0);
        next_drive();
        set_cpu(1'b0, 1'b0, '0, '0);
        @(negedge clock);
        chk("b2b_rvalid", 32'(cpu_if.rvalid), 32'd1);
        chk("b2b_rdata", 32'(cpu_if.rdata), 32'hAAAA);

        // Continuous CPU traffic against a host read of 0x30
        next_drive();
        set_cpu(1'b1, 1'b0, 8'h00, '0);
        set_host(1'b1, 1'b0, 8'h30, '0);
        gnt_cycle = 0;
        cpu_at    = 1'b1;
        wait_at   = 8'd0;
        for (int n = 1; n <= STARVE_BOUND; n++) begin
            @(negedge clock);
            if (host_if.gnt) begin
                gnt_cycle = n;
                cpu_at    = cpu_if.gnt;
                wait_at   = host_wait;
                break;
            end
        end
`ifdef DMEM_ARB_STARVE_EN
        chk("starve_gnt_cycle", 32'(gnt_cycle), 32'd9);
        chk("starve_cpu_gnt", 32'(cpu_at), 32'd0);
        chk("starve_wait_at_gnt", 32'(wait_at), 32'(MAX_WAIT));
        next_drive();
        set_host(1'b0, 1'b0, '0, '0);
        @(negedge clock);
        chk("starve_rvalid", 32'(host_if.rvalid), 32'd1);
        chk("starve_rdata", 32'(host_if.rdata), 32'h5A5A);
        chk("starve_wait_clr", 32'(host_wait), 32'd0);
        next_drive();
        set_cpu(1'b0, 1'b0, '0, '0);
`else
        chk("nostarve_gnt_seen", 32'(gnt_cycle), 32'd0);
        chk("nostarve_wait_sat", 32'(host_wait), 32'd255);
        next_drive();
        set_cpu(1'b0, 1'b0, '0, '0);
        @(negedge clock);
        chk("nostarve_release_gnt", 32'(host_if.gnt), 32'd1);
        next_drive();
        set_host(1'b0, 1'b0, '0, '0);
        @(negedge clock);
        chk("nostarve_rvalid", 32'(host_if.rvalid), 32'd1);
        chk("nostarve_rdata", 32'(host_if.rdata), 32'h5A5A);
        chk("nostarve_wait_clr", 32'(host_wait), 32'd0);
`endif

        // Reset asserted the cycle after a CPU read grant
        next_drive();
        set_cpu(1'b1, 1'b0, 8'h20, '0);
        @(negedge clock);
        chk("rmid_gnt", 32'(cpu_if.gnt), 32'd1);
        next_drive();
        set_cpu(1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        #1;
        cpu_q.delete();
        host_q.delete();
        chk("rmid_rvalid_cleared", 32'(cpu_if.rvalid), 32'd0);
        @(negedge clock);
        chk("rmid_rvalid_in_rst", 32'(cpu_if.rvalid), 32'd0);
        next_drive();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rmid_post_cpu_rvalid", 32'(cpu_if.rvalid), 32'd0);
            chk("rmid_post_host_rvalid", 32'(host_if.rvalid), 32'd0);
        end

        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 256x16 data memory between the pipeline's MEM stage (CPU port) and a host load/dump port used by bring-up and test. CPU requests have priority; host requests are served when the CPU port is idle. An optional anti-starvation counter forces a host slot after a bounded wait. The block sits between the processor core, the host interface and the `dmem` RAM instance inside `processor`.

## Interface
Parameters:
- AW, 8, memory address width (256 words)
- DW, 16, data width
- MAX_WAIT, 8, host wait cycles before a forced grant (used only with the macro); range 1..255

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, valid this cycle
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- cpu_rvalid  out  1  CPU read data valid (registered)
- cpu_rdata  out  DW  CPU read data
- host_req, host_we, host_addr, host_wdata  in  1/1/AW/DW  host request, same meaning as the CPU port
- host_gnt  out  1  host access accepted this cycle (combinational)
- host_rvalid  out  1  host read data valid (registered)
- host_rdata  out  DW  host read data
- mem_en, mem_we  out  1  RAM enable and write strobe
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid one cycle after a read enable
- host_wait  out  8  current host wait count (debug)

## Operation
- Arbitration happens every cycle; at most one access is issued per cycle.
- Default winner: CPU if cpu_req, else host if host_req.
- A request is accepted in any cycle where req && gnt. The requester holds req, addr, we and wdata stable until it sees gnt.
- mem_en = cpu_gnt | host_gnt. mem_we, mem_addr and mem_wdata are muxed from the winner. When neither port is granted, mem_addr and mem_wdata are 0.
- Read return:
  - One owner flag is registered per accepted read: CPU, host or none.
  - The next cycle, the owner's rvalid = 1 and its rdata = mem_rdata. The other port's rdata holds 0.
  - Writes produce no rvalid.
- host_wait increments each cycle that host_req && !host_gnt, saturating at 255. It clears to 0 on host_gnt, and also when host_req is low.
- Back-to-back accesses are allowed every cycle. Read-after-write to the same address in consecutive cycles returns the new data, because the RAM is write-first.

## Timing
- Reset values: cpu_rvalid = host_rvalid = 0, cpu_rdata = host_rdata = 0, owner = none, host_wait = 0. gnt and mem_* outputs follow the reset-state inputs combinationally.
- Grant latency: 0 cycles. Read latency: 1 cycle from gnt to rvalid.
- Simultaneous requests with no forced slot: the CPU wins and the host waits.
- Reset asserted mid-access clears the owner and rvalid immediately. The in-flight read result is discarded and no rvalid is produced after release.
- cpu_gnt low while cpu_req is high is the pipeline stall indication. The core freezes its MEM stage.

## Configuration
- DMEM_ARB_STARVE_EN defined:
  - When host_wait == MAX_WAIT and host_req is high, the host wins that cycle over the CPU. cpu_gnt = 0, which stalls the core for one cycle.
  - host_wait then clears.
- DMEM_ARB_STARVE_EN undefined:
  - Pure fixed priority. A continuously requesting CPU starves the host indefinitely.
  - host_wait is still counted for debug.

## Structure
- Shared package `processor_pkg`:
  - AW and DW defaults
  - owner encoding localparams: OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_HOST = 2'd2
- One sub-module, `arb_wait_counter`: the saturating 8-bit wait counter with clear and compare-to-MAX_WAIT output. Everything else stays inline.

## Test plan
- Reset: hold reset = 0 with random requests. Required: all rvalids 0 and host_wait 0. After release, the first host-only read of address 0x10 (RAM preloaded 0x1234) gives host_gnt = 1, then host_rvalid = 1 and host_rdata = 0x1234 the next cycle.
- Contention:
  - Stimulus: cpu_req and host_req both high in the same cycle; CPU reads 0x05, host writes 0xBEEF to 0x06.
  - Required: cpu_gnt = 1 and host_gnt = 0 in that cycle. The host is granted the next cycle, when cpu_req drops. RAM[0x06] = 0xBEEF afterwards.
- Back-to-back:
  - Stimulus: CPU writes 0xAAAA to 0x20, then reads 0x20 the next cycle.
  - Required: cpu_rvalid one cycle after the read gnt, with rdata = 0xAAAA.
- Starvation, with DMEM_ARB_STARVE_EN and MAX_WAIT = 8:
  - Stimulus: CPU requests every cycle while the host reads 0x30.
  - Required: host_gnt = 1 exactly on the 9th cycle of host_req, with cpu_gnt = 0 in that cycle. The following cycle host_rdata equals RAM[0x30] and host_wait returns to 0.
- Starvation without the macro: same stimulus for 300 cycles. Required: host_gnt never 1 and host_wait saturates at 255.
- Reset mid-read: assert reset in the cycle after a CPU read gnt. Required: cpu_rvalid stays 0 and no spurious rvalid appears after release.
